// File: rtl/apb_master.sv
// apb_master: APB requester bridging a one-outstanding valid/ready command channel
// and a valid/ready response channel onto a single APB SETUP+ACCESS transfer.
// Optional feature macro: APB_TIMEOUT_EN enables the ACCESS-phase watchdog
// (abort after TIMEOUT_CYC unanswered ACCESS cycles). Without it, ACCESS waits
// indefinitely and rsp_timeout is constantly 0.
module apb_master #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              preset,
    // host command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // host response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB requester side
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cyc
        $error("apb_master: TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic              cmd_ready_q,   cmd_ready_d;
    logic              psel_q,        psel_d;
    logic              penable_q,     penable_d;
    logic              pwrite_q,      pwrite_d;
    logic [ADDR_W-1:0] paddr_q,       paddr_d;
    logic [DATA_W-1:0] pwdata_q,      pwdata_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic              rsp_err_q,     rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic cmd_accept;
    logic timeout_hit;

    assign cmd_accept = cmd_valid && cmd_ready_q;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Watchdog next value: cleared in SETUP so it starts at 0 on entry to ACCESS,
    // then counts every ACCESS cycle that ends without pready.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_SETUP) begin
            tmo_cnt_d = '0;
        end else if ((state_q == S_ACCESS) && !pready) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // The edge that would make the count reach TIMEOUT_CYC is the abort edge;
    // pready on that same edge takes priority (normal completion).
    assign timeout_hit = (state_q == S_ACCESS) && !pready &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register and all registered outputs.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state logic: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values; every field holds unless the current state changes it.
    always_comb begin
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                cmd_ready_d   = 1'b1;
                psel_d        = 1'b0;
                penable_d     = 1'b0;
                pwrite_d      = 1'b0;
                paddr_d       = '0;
                pwdata_d      = '0;
                rsp_valid_d   = 1'b0;
                rsp_rdata_d   = '0;
                rsp_err_d     = 1'b0;
                rsp_timeout_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven directed bench for apb_master with a small
// behavioural APB slave (32-word memory, pslverr for addresses >= 32).
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [32];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one command, play the slave with 'waits' wait states, then hold
    // rsp_ready low for 'hold' cycles while offering a competing command.
    task automatic run_txn(input vec_t v, input int idx);
        int cyc;
        int w;
        logic [31:0] held;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge pclk);
        chk({tag, ".cmd_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cyc = 1;
        chk({tag, ".setup_psel"},    {31'd0, psel},    32'd1);
        chk({tag, ".setup_penable"}, {31'd0, penable}, 32'd0);
        w = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge pclk);
            cyc++;
            if (rsp_valid) break;
            if (psel && penable) begin
                chk({tag, ".access_paddr"},  paddr, v.addr);
                chk({tag, ".access_pwrite"}, {31'd0, pwrite}, {31'd0, v.wr});
                if (v.wr) chk({tag, ".access_pwdata"}, pwdata, v.wdata);
                if (w == v.waits) begin
                    pready  = 1'b1;
                    pslverr = (v.addr >= 32);
                    if (v.addr >= 32)  prdata = 32'hBAD0BAD0;
                    else if (v.wr)     prdata = 32'hA5A5A5A5;
                    else               prdata = mem[v.addr[4:0]];
                    if (v.wr && v.addr < 32) mem[v.addr[4:0]] = v.wdata;
                end else begin
                    pready = 1'b0;
                    w++;
                end
            end else begin
                pready = 1'b0;
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        chk({tag, ".rsp_valid_seen"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".latency"}, cyc, 3 + v.waits);
        chk({tag, ".rsp_rdata"},   rsp_rdata, v.exp_rdata);
        chk({tag, ".rsp_err"},     {31'd0, rsp_err},     {31'd0, v.exp_err});
        chk({tag, ".rsp_timeout"}, {31'd0, rsp_timeout}, 32'd0);
        chk({tag, ".rsp_psel"},    {31'd0, psel},        32'd0);
        held = rsp_rdata;
        // competing command while the response is pending must not be taken
        cmd_valid = 1'b1;
        cmd_write = ~v.wr;
        cmd_addr  = 32'h0000_0077;
        cmd_wdata = 32'h1111_2222;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge pclk);
            chk({tag, ".hold_valid"},     {31'd0, rsp_valid}, 32'd1);
            chk({tag, ".hold_rdata"},     rsp_rdata, held);
            chk({tag, ".hold_err"},       {31'd0, rsp_err}, {31'd0, v.exp_err});
            chk({tag, ".hold_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
            chk({tag, ".hold_psel"},      {31'd0, psel}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk({tag, ".post_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, ".post_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, ".post_psel"},      {31'd0, psel}, 32'd0);
        chk({tag, ".post_paddr_kept"}, paddr, v.addr);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 32; i++) mem[i] = i * 32'h01010101;

        //          wr    addr   wdata          waits hold exp_rdata      exp_err
        vecs[0] = '{1'b1, 32'd5,  32'hDEADBEEF, 0,    0,   32'h00000000,  1'b0};
        vecs[1] = '{1'b0, 32'd5,  32'h00000000, 0,    0,   32'hDEADBEEF,  1'b0};
        vecs[2] = '{1'b0, 32'd40, 32'h00000000, 0,    0,   32'h00000000,  1'b1};
        vecs[3] = '{1'b1, 32'd7,  32'h12345678, 2,    3,   32'h00000000,  1'b0};
        vecs[4] = '{1'b0, 32'd7,  32'h00000000, 1,    3,   32'h12345678,  1'b0};
        vecs[5] = '{1'b1, 32'd40, 32'hFFFF0000, 0,    1,   32'h00000000,  1'b1};
        vecs[6] = '{1'b0, 32'd6,  32'h00000000, 3,    0,   32'h06060606,  1'b0};

        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst.cmd_ready",   {31'd0, cmd_ready},   32'd1);
        chk("rst.psel",        {31'd0, psel},        32'd0);
        chk("rst.penable",     {31'd0, penable},     32'd0);
        chk("rst.pwrite",      {31'd0, pwrite},      32'd0);
        chk("rst.paddr",       paddr,                32'd0);
        chk("rst.pwdata",      pwdata,               32'd0);
        chk("rst.rsp_valid",   {31'd0, rsp_valid},   32'd0);
        chk("rst.rsp_rdata",   rsp_rdata,            32'd0);
        chk("rst.rsp_err",     {31'd0, rsp_err},     32'd0);
        chk("rst.rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        preset = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

        // Reset in the middle of ACCESS with pready low: response must vanish.
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'd9;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk("mrst.in_access", {31'd0, penable}, 32'd1);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        chk("mrst.psel",      {31'd0, psel},      32'd0);
        chk("mrst.penable",   {31'd0, penable},   32'd0);
        chk("mrst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mrst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mrst.paddr",     paddr,              32'd0);
        pready = 1'b1;
        repeat (3) @(negedge pclk);
        pready = 1'b0;
        chk("mrst.no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("mrst.idle_psel",    {31'd0, psel},      32'd0);

        // Slave never answers: watchdog abort, or indefinite wait without it.
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'd3;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cyc = 1;
`ifdef APB_TIMEOUT_EN
        for (int c = 0; c < 50; c++) begin
            @(negedge pclk);
            cyc++;
            if (rsp_valid) break;
        end
        chk("tmo.rsp_valid",   {31'd0, rsp_valid},   32'd1);
        chk("tmo.latency",     cyc,                  32'd6);
        chk("tmo.rsp_err",     {31'd0, rsp_err},     32'd1);
        chk("tmo.rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
        chk("tmo.rsp_rdata",   rsp_rdata,            32'd0);
        chk("tmo.psel",        {31'd0, psel},        32'd0);
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("tmo.post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`else
        while (cyc < 100) begin
            @(negedge pclk);
            cyc++;
            if (rsp_valid) break;
        end
        chk("wait.rsp_valid_c100", {31'd0, rsp_valid},      32'd0);
        chk("wait.access_c100",    {31'd0, psel && penable}, 32'd1);
        chk("wait.rsp_timeout",    {31'd0, rsp_timeout},     32'd0);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        chk("wait.reset_psel", {31'd0, psel}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
